// File: rtl/ps2_key_decoder_if.sv
// Key-event bus from the PS/2 decoder to the player-control logic.
// The decoder drives the master side and game logic listens on the slave side.
interface ps2_key_decoder_if #(
  parameter int NUM_KEYS = 10
);
  logic [7:0]          code;
  logic                code_ext;
  logic                code_brk;
  logic                code_valid;
  logic [NUM_KEYS-1:0] key_held;
  logic                frame_err;

  modport master (
    output code,
    output code_ext,
    output code_brk,
    output code_valid,
    output key_held,
    output frame_err
  );

  modport slave (
    input code,
    input code_ext,
    input code_brk,
    input code_valid,
    input key_held,
    input frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronise and filter the lines, frame bytes, strip E0/F0
// prefixes into one event per key action, and track held state for a table of game keys.
module ps2_key_decoder #(
  parameter int                    NUM_KEYS    = 10,
  parameter logic [NUM_KEYS*9-1:0] KEYMAP      = {9'h00D, 9'h023, 9'h01B, 9'h01C, 9'h01D,
                                                  9'h029, 9'h174, 9'h16B, 9'h172, 9'h175},
  parameter int                    FILTER_LEN  = 8,
  parameter int                    TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_key_decoder_if.master evt
);

  localparam int              TOW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      FLIM  = 8'(FILTER_LEN - 1);
  localparam logic [TOW-1:0]  TOLIM = TOW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // index 0 = ps2_clk, index 1 = ps2_data
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          filt_q, filt_d;
  logic [7:0]          fcnt_q [2];
  logic [7:0]          fcnt_d [2];
  logic                clk_prev_q, clk_prev_d;

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic [TOW-1:0]      to_cnt_q, to_cnt_d;
  logic                byte_done_q, byte_done_d;
  logic                frame_err_q, frame_err_d;

  logic                ext_pend_q, ext_pend_d;
  logic                brk_pend_q, brk_pend_d;
  logic [7:0]          code_q, code_d;
  logic                code_ext_q, code_ext_d;
  logic                code_brk_q, code_brk_d;
  logic                code_valid_q, code_valid_d;
  logic [NUM_KEYS-1:0] key_held_q, key_held_d;

  logic                fall_s;
  logic                data_s;
  logic                timeout_s;

  // A filtered line only follows the synchronised input after FILTER_LEN agreeing samples.
  always_comb begin
    sync1_d    = {ps2_data, ps2_clk};
    sync2_d    = sync1_q;
    clk_prev_d = filt_q[0];
    filt_d     = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = 8'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FLIM) begin
          filt_d[i] = sync2_q[i];
          fcnt_d[i] = 8'd0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 8'd1;
        end
      end else begin
        fcnt_d[i] = 8'd0;
      end
    end
  end

  assign fall_s    = clk_prev_q & ~filt_q[0];
  assign data_s    = filt_q[1];
  assign timeout_s = (state_q != ST_IDLE) && !fall_s && (to_cnt_q == TOLIM);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_done_d = 1'b0;
    frame_err_d = 1'b0;
    if ((state_q == ST_IDLE) || fall_s || timeout_s) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TOW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_s && !data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          par_d   = data_s;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          if (data_s && odd_parity_ok(shift_q, par_q)) begin
            byte_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A fall in the same cycle keeps timeout_s low, so the fall always wins.
    if (timeout_s) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = frame_err_d;
    end
  end

  // Prefix/event stage works on the completed byte still sitting in shift_q.
  always_comb begin
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    code_d       = code_q;
    code_ext_d   = code_ext_q;
    code_brk_d   = code_brk_q;
    code_valid_d = 1'b0;
    key_held_d   = key_held_q;

    if (frame_err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_done_q) begin
      case (shift_q)
        8'hE0: begin
          ext_pend_d = 1'b1;
        end
        8'hF0: begin
          brk_pend_d = 1'b1;
        end
        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h00, 8'hFF: begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
        default: begin
          code_valid_d = 1'b1;
          code_d       = shift_q;
          code_ext_d   = ext_pend_q;
          code_brk_d   = brk_pend_q;
          ext_pend_d   = 1'b0;
          brk_pend_d   = 1'b0;
          for (int i = 0; i < NUM_KEYS; i++) begin
            if (KEYMAP[9*i +: 9] == {ext_pend_q, shift_q}) begin
              key_held_d[i] = ~brk_pend_q;
            end else begin
              key_held_d[i] = key_held_q[i];
            end
          end
        end
      endcase
    end else begin
      code_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 2'b11;
      sync2_q      <= 2'b11;
      filt_q       <= 2'b11;
      fcnt_q[0]    <= 8'd0;
      fcnt_q[1]    <= 8'd0;
      clk_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      code_q       <= 8'd0;
      code_ext_q   <= 1'b0;
      code_brk_q   <= 1'b0;
      code_valid_q <= 1'b0;
      key_held_q   <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      filt_q       <= filt_d;
      fcnt_q[0]    <= fcnt_d[0];
      fcnt_q[1]    <= fcnt_d[1];
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      byte_done_q  <= byte_done_d;
      frame_err_q  <= frame_err_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      code_q       <= code_d;
      code_ext_q   <= code_ext_d;
      code_brk_q   <= code_brk_d;
      code_valid_q <= code_valid_d;
      key_held_q   <= key_held_d;
    end
  end

  assign evt.code       = code_q;
  assign evt.code_ext   = code_ext_q;
  assign evt.code_brk   = code_brk_q;
  assign evt.code_valid = code_valid_q;
  assign evt.key_held   = key_held_q;
  assign evt.frame_err  = frame_err_q;

endmodule
